// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge on one clock; PSLVERR->HRESP error path only when BRIDGE_ERR_EN is defined.
// Latency: at least 3 data-phase cycles per transfer (SETUP, ACCESS, completion), plus one cycle per PREADY wait state.
// Backpressure: HREADYOUT stays low from accept until ACCESS completes; address phases seen while busy are ignored.

module ahb_apb_bridge #(
   parameter int ADDR_W = 8
) (
   input  logic              PCLK,
   input  logic              PRESET,
   // AHB-Lite slave side
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [31:0]       HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [31:0]       HRDATA,
   // APB master side
   output logic [ADDR_W-1:0] PADDR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [31:0]       PWDATA,
   input  logic [31:0]       PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

`ifdef BRIDGE_ERR_EN
   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;
`endif

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic                pwrite_q, pwrite_d;
   logic [31:0]         hrdata_q, hrdata_d;
   logic                hreadyout_q, hreadyout_d;
   logic                accept;

   // Upper address bits are decoded upstream; PSLVERR is only consumed by the error path.
   logic                unused_bits;
   assign unused_bits = ^{HADDR[31:ADDR_W], PSLVERR};

`ifdef BRIDGE_ERR_EN
   logic                hresp_q, hresp_d;
`endif

   // A valid NONSEQ/SEQ address phase addressed to us on a ready bus.
   assign accept = HSEL & HTRANS[1] & HREADY;

   // Next-state and registered-output logic; HREADYOUT/HRESP are computed for the state being entered.
   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      hrdata_d    = hrdata_q;
      hreadyout_d = hreadyout_q;
`ifdef BRIDGE_ERR_EN
      hresp_d     = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            hreadyout_d = 1'b1;
            if (accept) begin
               state_d     = ST_SETUP;
               paddr_d     = HADDR[ADDR_W-1:0];
               pwrite_d    = HWRITE;
               hreadyout_d = 1'b0;
            end
         end
         ST_SETUP: begin
            state_d     = ST_ACCESS;
            hreadyout_d = 1'b0;
         end
         ST_ACCESS: begin
            hreadyout_d = 1'b0;
            if (PREADY) begin
`ifdef BRIDGE_ERR_EN
               if (PSLVERR) begin
                  // First error cycle: HRESP up while HREADYOUT still low.
                  state_d = ST_ERR1;
                  hresp_d = 1'b1;
               end else begin
                  state_d     = ST_IDLE;
                  hreadyout_d = 1'b1;
                  if (!pwrite_q) hrdata_d = PRDATA;
               end
`else
               state_d     = ST_IDLE;
               hreadyout_d = 1'b1;
               if (!pwrite_q) hrdata_d = PRDATA;
`endif
            end
         end
`ifdef BRIDGE_ERR_EN
         ST_ERR1: begin
            // Second error cycle: HRESP held, HREADYOUT released; no accept here.
            state_d     = ST_ERR2;
            hresp_d     = 1'b1;
            hreadyout_d = 1'b1;
         end
         ST_ERR2: begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
         end
`endif
         default: begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
         end
      endcase
   end

   // State and captured transfer attributes; reset aborts any transfer in flight.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q     <= ST_IDLE;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         hrdata_q    <= '0;
         hreadyout_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         hrdata_q    <= hrdata_d;
         hreadyout_q <= hreadyout_d;
      end
   end

`ifdef BRIDGE_ERR_EN
   // Error response register, only present with the error path.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) hresp_q <= 1'b0;
      else        hresp_q <= hresp_d;
   end
   assign HRESP = hresp_q;
`else
   assign HRESP = 1'b0;
`endif

   assign HREADYOUT = hreadyout_q;
   assign HRDATA    = hrdata_q;
   assign PADDR     = paddr_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = HWDATA;
   // PENABLE only in ACCESS, which always implies PSEL.
   assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign PENABLE   = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: transfer-level model plus directed AHB transfers with a scripted APB slave.
// Latency: model predicts outputs per cycle from accept time and PREADY/PSLVERR seen at each edge.
// Backpressure: APB wait states come from the scripted PREADY; the bench holds HWDATA while HREADYOUT is low.

module tb_ahb_apb_bridge;
   localparam int AW = 8;
   localparam int TN = 512;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic          HSEL, HWRITE, HREADY;
   logic [31:0]   HADDR, HWDATA;
   logic [1:0]    HTRANS;
   logic          HREADYOUT, HRESP;
   logic [31:0]   HRDATA;
   logic [AW-1:0] PADDR;
   logic          PSEL, PENABLE, PWRITE;
   logic [31:0]   PWDATA, PRDATA;
   logic          PREADY, PSLVERR;

   ahb_apb_bridge #(.ADDR_W(AW)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
      .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

`ifdef BRIDGE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge PCLK) cyc <= cyc + 1;

   // Transfer-level model: a transfer occupies the APB from accept until PREADY is seen
   // in its second or later cycle; an APB error adds two response cycles.
   bit          m_busy   = 1'b0;
   int          m_t      = 0;     // cycles since accept (1 = setup cycle)
   int          m_err    = 0;     // 0 none, 1 first error cycle, 2 second error cycle
   logic [AW-1:0] m_paddr = '0;
   logic        m_pwrite = 1'b0;
   logic [31:0] m_hrdata = '0;

   always @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         m_busy = 1'b0; m_t = 0; m_err = 0;
         m_paddr = '0; m_pwrite = 1'b0; m_hrdata = '0;
      end else if (m_err != 0) begin
         m_err = (m_err == 1) ? 2 : 0;
      end else if (m_busy) begin
         if (m_t >= 2 && PREADY) begin
            m_busy = 1'b0;
            if (ERR_EN && PSLVERR) m_err = 1;
            else if (!m_pwrite)    m_hrdata = PRDATA;
         end else begin
            m_t++;
         end
      end else if (HSEL && HTRANS[1] && HREADY) begin
         m_busy   = 1'b1;
         m_t      = 1;
         m_paddr  = HADDR[AW-1:0];
         m_pwrite = HWRITE;
      end
   end

   // Per-cycle trace of DUT outputs, for the hand-computed checks.
   bit          tr_psel [TN];
   bit          tr_pen  [TN];
   bit          tr_hro  [TN];
   bit          tr_hresp[TN];
   bit          tr_pwr  [TN];
   logic [AW-1:0] tr_paddr [TN];
   logic [31:0] tr_hrdata[TN];
   logic [31:0] tr_pwdata[TN];

   // Compare process: every cycle, mid-period.
   always @(negedge PCLK) begin
      chk("psel",      32'(PSEL),      32'(m_busy));
      chk("penable",   32'(PENABLE),   32'(m_busy && m_t >= 2));
      chk("hreadyout", 32'(HREADYOUT), 32'(!(m_busy || m_err == 1)));
      chk("hresp",     32'(HRESP),     32'(m_err != 0));
      chk("hrdata",    HRDATA,         m_hrdata);
      chk("paddr",     32'(PADDR),     32'(m_paddr));
      chk("pwrite",    32'(PWRITE),    32'(m_pwrite));
      chk("pwdata",    PWDATA,         HWDATA);
      if (cyc < TN) begin
         tr_psel[cyc] = PSEL;   tr_pen[cyc] = PENABLE; tr_hro[cyc] = HREADYOUT;
         tr_hresp[cyc] = HRESP; tr_pwr[cyc] = PWRITE;  tr_paddr[cyc] = PADDR;
         tr_hrdata[cyc] = HRDATA; tr_pwdata[cyc] = PWDATA;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge PCLK); #1; end
   endtask

   // Present one address phase; acc becomes the index of the setup cycle.
   task automatic addr_phase(input logic [7:0] a, input logic w);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = {24'h0, a}; HWRITE = w; HREADY = 1'b1;
      @(posedge PCLK); #1;
      acc = cyc;
      HSEL = 1'b0; HTRANS = 2'b00;
   endtask

   // Data phase from setup cycle to completion edge, with a scripted APB slave.
   task automatic data_phase(input logic [31:0] wd, input int waits,
                             input logic [31:0] rd, input logic err);
      HWDATA = wd;
      @(posedge PCLK); #1;
      PRDATA = rd; PSLVERR = err; PREADY = (waits == 0);
      for (int i = 0; i < waits; i++) begin
         @(posedge PCLK); #1;
         PREADY = (i == waits - 1);
      end
      @(posedge PCLK); #1;
      PREADY = 1'b0; PSLVERR = 1'b0;
   endtask

   initial begin
      int a, b, lows, t0;
      PRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
      HWDATA = '0; HREADY = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      @(posedge PCLK); #1;
      chk("rst hreadyout", 32'(HREADYOUT), 32'd1);
      chk("rst psel",      32'(PSEL),      32'd0);
      chk("rst penable",   32'(PENABLE),   32'd0);
      chk("rst hresp",     32'(HRESP),     32'd0);
      chk("rst hrdata",    HRDATA,         32'd0);
      chk("rst paddr",     32'(PADDR),     32'd0);
      chk("rst pwrite",    32'(PWRITE),    32'd0);
      PRESET = 1'b0;
      idle(1);

      // Single write, no wait states.
      addr_phase(8'h00, 1'b1); a = acc;
      data_phase(32'h64, 0, 32'h0, 1'b0);
      idle(1);
      chk("wr psel N+1",    32'(tr_psel[a]),   32'd1);
      chk("wr penable N+1", 32'(tr_pen[a]),    32'd0);
      chk("wr penable N+2", 32'(tr_pen[a+1]),  32'd1);
      chk("wr hro N+1",     32'(tr_hro[a]),    32'd0);
      chk("wr hro N+2",     32'(tr_hro[a+1]),  32'd0);
      chk("wr hro N+3",     32'(tr_hro[a+2]),  32'd1);
      chk("wr paddr",       32'(tr_paddr[a+1]), 32'h00);
      chk("wr pwdata",      tr_pwdata[a+1],    32'h64);
      chk("wr pwrite",      32'(tr_pwr[a]),    32'd1);
      chk("wr hrdata kept", tr_hrdata[a+2],    32'h0);

      // Single read, no wait states.
      addr_phase(8'h04, 1'b0); a = acc;
      data_phase(32'h0, 0, 32'h0000002A, 1'b0);
      idle(1);
      chk("rd hrdata before", tr_hrdata[a+1], 32'h0);
      chk("rd hrdata N+3",    tr_hrdata[a+2], 32'h2A);
      chk("rd hro N+3",       32'(tr_hro[a+2]), 32'd1);
      chk("rd paddr",         32'(tr_paddr[a]), 32'h04);
      chk("rd pwrite N+1",    32'(tr_pwr[a]),   32'd0);
      chk("rd pwrite N+2",    32'(tr_pwr[a+1]), 32'd0);

      // Read with three ACCESS wait cycles.
      addr_phase(8'h0C, 1'b0); a = acc;
      data_phase(32'h0, 3, 32'hDEADBEEF, 1'b0);
      idle(1);
      lows = 0;
      for (int k = 0; k < 6; k++) if (!tr_hro[a+k]) lows++;
      chk("wait hro low cycles", 32'(lows), 32'd5);
      chk("wait hro release",    32'(tr_hro[a+5]), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         chk("wait psel stable",    32'(tr_psel[a+k]),  32'd1);
         chk("wait penable stable", 32'(tr_pen[a+k]),   32'd1);
         chk("wait paddr stable",   32'(tr_paddr[a+k]), 32'h0C);
      end
      chk("wait hrdata", tr_hrdata[a+5], 32'hDEADBEEF);

      // Back-to-back writes: second address phase presented as HREADYOUT rises.
      addr_phase(8'h08, 1'b1); a = acc;
      data_phase(32'h11, 0, 32'h0, 1'b0);
      addr_phase(8'h00, 1'b1);
      data_phase(32'h22, 0, 32'h0, 1'b0);
      idle(1);
      chk("b2b hro first done",  32'(tr_hro[a+2]),   32'd1);
      chk("b2b first paddr",     32'(tr_paddr[a+2]), 32'h08);
      chk("b2b second setup",    32'(tr_psel[a+3]),  32'd1);
      chk("b2b second no pen",   32'(tr_pen[a+3]),   32'd0);
      chk("b2b second paddr",    32'(tr_paddr[a+3]), 32'h00);
      chk("b2b second access",   32'(tr_pen[a+4]),   32'd1);
      chk("b2b second pwdata",   tr_pwdata[a+4],     32'h22);

      // Selected but IDLE/BUSY, and NONSEQ with HREADY low: no transfer.
      HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h40; t0 = cyc;
      idle(1);
      HTRANS = 2'b00;
      idle(1);
      HTRANS = 2'b10; HREADY = 1'b0;
      idle(1);
      HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
      idle(1);
      for (int k = 1; k <= 3; k++) begin
         chk("nop psel", 32'(tr_psel[t0+k]), 32'd0);
         chk("nop hro",  32'(tr_hro[t0+k]),  32'd1);
      end

      // Address phase held by the master while busy is taken only after completion.
      addr_phase(8'h10, 1'b0); a = acc;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h33; HWRITE = 1'b1;
      data_phase(32'h5A5A, 2, 32'h77, 1'b0);
      addr_phase(8'h33, 1'b1); b = acc;
      data_phase(32'h99, 0, 32'h0, 1'b0);
      idle(1);
      chk("held paddr kept",  32'(tr_paddr[a+3]), 32'h10);
      chk("held pwrite kept", 32'(tr_pwr[a+3]),   32'd0);
      chk("held hrdata",      tr_hrdata[a+4],     32'h77);
      chk("held next setup",  32'(tr_psel[a+5]),  32'd1);
      chk("held next paddr",  32'(tr_paddr[a+5]), 32'h33);
      chk("held next pwrite", 32'(tr_pwr[b]),     32'd1);

      // Slave error response.
      addr_phase(8'h14, 1'b0); a = acc;
      data_phase(32'h0, 0, 32'hC3, 1'b1);
`ifdef BRIDGE_ERR_EN
      idle(3);
      chk("err hresp c1",   32'(tr_hresp[a+2]), 32'd1);
      chk("err hresp c2",   32'(tr_hresp[a+3]), 32'd1);
      chk("err hro c1",     32'(tr_hro[a+2]),   32'd0);
      chk("err hro c2",     32'(tr_hro[a+3]),   32'd1);
      chk("err hresp end",  32'(tr_hresp[a+4]), 32'd0);
      chk("err hrdata kept", tr_hrdata[a+4],    32'h77);
`else
      idle(1);
      for (int k = 0; k <= 2; k++) chk("noerr hresp", 32'(tr_hresp[a+k]), 32'd0);
      chk("noerr hrdata", tr_hrdata[a+2], 32'hC3);
      chk("noerr hro",    32'(tr_hro[a+2]), 32'd1);
`endif

      // Reset pulsed during ACCESS, then an immediate new transfer.
      addr_phase(8'h20, 1'b0); a = acc;
      HWDATA = 32'h0;
      @(posedge PCLK); #1;
      PREADY = 1'b0;
      #2 PRESET = 1'b1;
      #1;
      chk("arst psel",      32'(PSEL),      32'd0);
      chk("arst penable",   32'(PENABLE),   32'd0);
      chk("arst hreadyout", 32'(HREADYOUT), 32'd1);
      chk("arst paddr",     32'(PADDR),     32'd0);
      chk("arst hrdata",    HRDATA,         32'd0);
      chk("arst was access", 32'(tr_pen[a]), 32'd0);
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      addr_phase(8'h24, 1'b1); b = acc;
      data_phase(32'hAB, 0, 32'h0, 1'b0);
      idle(1);
      chk("arst pre access", 32'(tr_psel[a]),    32'd1);
      chk("post psel",       32'(tr_psel[b]),    32'd1);
      chk("post paddr",      32'(tr_paddr[b+1]), 32'h24);
      chk("post pwdata",     tr_pwdata[b+1],     32'hAB);
      chk("post hro",        32'(tr_hro[b+2]),   32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard stop so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
